// File: rtl/fifo_pkt_writer_if.sv
// Handshake bundle between the upstream packet source, fifo_pkt_writer and the
// write side of the async FIFO.
interface fifo_pkt_writer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;
  logic                  in_ready;
  logic                  fifo_full;
  logic                  fifo_overflow;
  logic                  fifo_wr;
  logic [DATA_WIDTH-1:0] fifo_wdata;
  logic                  pkt_sent;
  logic                  pkt_dropped;
  logic                  proto_err;

  modport master (
    output in_valid, in_data, in_last, fifo_full, fifo_overflow,
    input  in_ready, fifo_wr, fifo_wdata, pkt_sent, pkt_dropped, proto_err
  );

  modport slave (
    input  in_valid, in_data, in_last, fifo_full, fifo_overflow,
    output in_ready, fifo_wr, fifo_wdata, pkt_sent, pkt_dropped, proto_err
  );
endinterface

// File: rtl/fifo_pkt_writer.sv
// Stages a whole packet, then writes a length header followed by its words into
// an async FIFO; oversize packets are swallowed and reported with pkt_dropped.
module fifo_pkt_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_PKT    = 15
) (
  input logic              wr_clk,
  input logic              rst,
  fifo_pkt_writer_if.slave bus
);
  localparam int CW = $clog2(MAX_PKT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PKT);

  typedef enum logic [2:0] {IDLE, COLLECT, HEADER, DRAIN, DISCARD} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [CW-1:0]         idx, idx_nxt;
  logic [DATA_WIDTH-1:0] pkt_buf [MAX_PKT];
  logic                  buf_we;
  logic [CW-1:0]         buf_waddr;
  logic                  rdy, xfer, wr_en;
  logic                  sent_nxt, drop_nxt;
  logic                  sent_p1, drop_p1, err_p1;
  logic [DATA_WIDTH-1:0] wdata;

  assign rdy   = (state == IDLE || state == COLLECT || state == DISCARD) && !rst;
  assign xfer  = bus.in_valid && rdy;
  assign wr_en = (state == HEADER || state == DRAIN) && !bus.fifo_full && !rst;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    buf_we    = 1'b0;
    buf_waddr = cnt;
    sent_nxt  = 1'b0;
    drop_nxt  = 1'b0;
    wdata     = '0;
    case (state)
      IDLE: begin
        if (xfer) begin
          buf_we    = 1'b1;
          buf_waddr = '0;
          cnt_nxt   = CW'(1);
          state_nxt = bus.in_last ? HEADER : COLLECT;
        end
      end
      COLLECT: begin
        if (xfer) begin
          if (cnt < MAX_CNT) begin
            buf_we  = 1'b1;
            cnt_nxt = cnt + CW'(1);
            if (bus.in_last) state_nxt = HEADER;
          end else if (bus.in_last) begin
            drop_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = DISCARD;
          end
        end
      end
      HEADER: begin
        wdata = DATA_WIDTH'(cnt);
        if (wr_en) begin
          idx_nxt   = '0;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        wdata = pkt_buf[idx];
        if (wr_en) begin
          if (idx == cnt - CW'(1)) begin
            sent_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            idx_nxt = idx + CW'(1);
          end
        end
      end
      DISCARD: begin
        if (xfer && bus.in_last) begin
          drop_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // control registers: state, counters and status pulses
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      sent_p1 <= 1'b0;
      drop_p1 <= 1'b0;
      err_p1  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      sent_p1 <= sent_nxt;
      drop_p1 <= drop_nxt;
      err_p1  <= err_p1 | bus.fifo_overflow;
    end
  end

  // staging buffer: data path only, never reset
  always_ff @(posedge wr_clk) begin
    if (buf_we) pkt_buf[buf_waddr] <= bus.in_data;
  end

  assign bus.in_ready    = rdy;
  assign bus.fifo_wr     = wr_en;
  assign bus.fifo_wdata  = wdata;
  assign bus.pkt_sent    = sent_p1;
  assign bus.pkt_dropped = drop_p1;
  assign bus.proto_err   = err_p1;
endmodule

// File: tb/tb_fifo_pkt_writer.sv
// Bench for fifo_pkt_writer: packet-level queue model checked every cycle, plus
// directed scenarios with literal expected FIFO streams.
module tb_fifo_pkt_writer;
  localparam int MAX_PKT = 15;
  typedef logic [7:0] bq_t [$];

  logic wr_clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;

  fifo_pkt_writer_if #(.DATA_WIDTH(8)) bus ();

  fifo_pkt_writer #(.DATA_WIDTH(8), .MAX_PKT(MAX_PKT)) dut (
    .wr_clk (wr_clk),
    .rst    (rst),
    .bus    (bus.slave)
  );

  always #5 wr_clk = ~wr_clk;

  // Model: a packet becomes a list of owed FIFO words once its last word arrives.
  bq_t  mq;
  bq_t  cur;
  logic sent_m = 1'b0, drop_m = 1'b0, proto_m = 1'b0;

  always @(posedge wr_clk) begin
    cyc++;
    if (rst) begin
      mq.delete();
      cur.delete();
      sent_m  = 1'b0;
      drop_m  = 1'b0;
      proto_m = 1'b0;
    end else begin
      sent_m = 1'b0;
      drop_m = 1'b0;
      if (bus.fifo_overflow) proto_m = 1'b1;
      if (mq.size() > 0) begin
        if (!bus.fifo_full) begin
          void'(mq.pop_front());
          if (mq.size() == 0) sent_m = 1'b1;
        end
      end else if (bus.in_valid) begin
        cur.push_back(bus.in_data);
        if (bus.in_last) begin
          if (cur.size() <= MAX_PKT) begin
            mq.push_back(8'(cur.size()));
            foreach (cur[i]) mq.push_back(cur[i]);
          end else begin
            drop_m = 1'b1;
          end
          cur.delete();
        end
      end
    end
  end

  bq_t wlog;
  int  wedge[$];
  int  sedge[$];
  int  sent_cnt = 0, drop_cnt = 0, low_cnt = 0, acc_cnt = 0;
  int  last_acc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_log(input string nm, input int base, input bq_t exp);
    chk({nm, "_len"}, 32'(wlog.size() - base), 32'(exp.size()));
    foreach (exp[i])
      if (base + i < wlog.size()) chk(nm, 32'(wlog[base + i]), 32'(exp[i]));
  endtask

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] d, input logic last);
    int k;
    k = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    while (!bus.in_ready && k < 200) begin
      tick();
      k++;
    end
    chk("accept_timeout", 32'(k < 200), 32'd1);
    tick();
    last_acc     = cyc;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_pkt(input bq_t w);
    foreach (w[i]) send_word(w[i], i == w.size() - 1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    tick();
    while (!bus.in_ready && k < 300) begin
      tick();
      k++;
    end
    chk("idle_timeout", 32'(k < 300), 32'd1);
    repeat (2) tick();
  endtask

  int  b_log, b_sent, b_low, b_drop, b_acc, b_sedge;
  bq_t pkt;
  bq_t ex;

  initial begin
    rst               = 1'b1;
    bus.in_valid      = 1'b0;
    bus.in_data       = '0;
    bus.in_last       = 1'b0;
    bus.fifo_full     = 1'b0;
    bus.fifo_overflow = 1'b0;
    repeat (2) tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_fifo_wr", 32'(bus.fifo_wr), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("post_rst_pkt_sent", 32'(bus.pkt_sent), 32'd0);
    chk("post_rst_proto_err", 32'(bus.proto_err), 32'd0);
    chk("post_rst_wdata", 32'(bus.fifo_wdata), 32'd0);

    fork
      forever begin
        @(negedge wr_clk);
        chk("c_in_ready", 32'(bus.in_ready), 32'(!rst && mq.size() == 0));
        chk("c_fifo_wr", 32'(bus.fifo_wr), 32'(mq.size() > 0 && !bus.fifo_full && !rst));
        chk("c_fifo_wdata", 32'(bus.fifo_wdata), 32'(mq.size() > 0 ? mq[0] : 8'h00));
        chk("c_pkt_sent", 32'(bus.pkt_sent), 32'(sent_m));
        chk("c_pkt_dropped", 32'(bus.pkt_dropped), 32'(drop_m));
        chk("c_proto_err", 32'(bus.proto_err), 32'(proto_m));
        if (bus.fifo_wr === 1'b1) begin
          wlog.push_back(bus.fifo_wdata);
          wedge.push_back(cyc + 1);
        end
        if (bus.pkt_sent === 1'b1) begin
          sent_cnt++;
          sedge.push_back(cyc);
        end
        if (bus.pkt_dropped === 1'b1) drop_cnt++;
        if (bus.in_ready !== 1'b1 && !rst) low_cnt++;
        if (bus.in_valid && bus.in_ready === 1'b1) acc_cnt++;
      end
    join_none

    // three-word packet, no back-pressure
    b_log = wlog.size(); b_sent = sent_cnt; b_low = low_cnt;
    send_pkt('{8'hA1, 8'hB2, 8'hC3});
    wait_idle();
    chk_log("basic_log", b_log, '{8'h03, 8'hA1, 8'hB2, 8'hC3});
    if (wlog.size() >= b_log + 4) begin
      chk("basic_hdr_latency", 32'(wedge[b_log]), 32'(last_acc + 1));
      chk("basic_consecutive", 32'(wedge[b_log + 3] - wedge[b_log]), 32'd3);
    end
    chk("basic_sent", 32'(sent_cnt - b_sent), 32'd1);
    chk("basic_ready_low", 32'(low_cnt - b_low), 32'd4);

    // five-cycle full stall right after A1 is written
    b_log = wlog.size(); b_sent = sent_cnt;
    send_pkt('{8'hA1, 8'hB2, 8'hC3});
    tick();
    tick();
    bus.fifo_full = 1'b1;
    repeat (5) tick();
    bus.fifo_full = 1'b0;
    wait_idle();
    chk_log("stall_log", b_log, '{8'h03, 8'hA1, 8'hB2, 8'hC3});
    if (wlog.size() >= b_log + 3)
      chk("stall_gap", 32'(wedge[b_log + 2] - wedge[b_log + 1]), 32'd6);
    chk("stall_sent", 32'(sent_cnt - b_sent), 32'd1);

    // single-word packet followed immediately by another
    b_log = wlog.size(); b_sent = sent_cnt; b_sedge = sedge.size();
    send_pkt('{8'h5A});
    send_pkt('{8'h11, 8'h22});
    wait_idle();
    chk_log("b2b_log", b_log, '{8'h01, 8'h5A, 8'h02, 8'h11, 8'h22});
    chk("b2b_sent", 32'(sent_cnt - b_sent), 32'd2);
    if (wlog.size() >= b_log + 3 && sedge.size() > b_sedge)
      chk("b2b_hdr_after_sent", 32'(wedge[b_log + 2] >= sedge[b_sedge] + 1), 32'd1);

    // exactly MAX_PKT words is still written
    b_log = wlog.size();
    pkt.delete();
    for (int i = 1; i <= MAX_PKT; i++) pkt.push_back(8'(8'h40 + i));
    send_pkt(pkt);
    wait_idle();
    ex = pkt;
    ex.push_front(8'h0F);
    chk_log("max_log", b_log, ex);

    // 16 words: last word lands exactly when the buffer is full
    b_log = wlog.size(); b_drop = drop_cnt;
    pkt.delete();
    for (int i = 1; i <= 16; i++) pkt.push_back(8'(i));
    send_pkt(pkt);
    wait_idle();
    chk("drop16_writes", 32'(wlog.size() - b_log), 32'd0);
    chk("drop16_dropped", 32'(drop_cnt - b_drop), 32'd1);

    // 17 words goes through DISCARD
    b_log = wlog.size(); b_drop = drop_cnt; b_acc = acc_cnt; b_sent = sent_cnt;
    pkt.delete();
    for (int i = 1; i <= 17; i++) pkt.push_back(8'(i));
    send_pkt(pkt);
    wait_idle();
    chk("drop17_writes", 32'(wlog.size() - b_log), 32'd0);
    chk("drop17_dropped", 32'(drop_cnt - b_drop), 32'd1);
    chk("drop17_accepted", 32'(acc_cnt - b_acc), 32'd17);
    chk("drop17_sent", 32'(sent_cnt - b_sent), 32'd0);
    b_log = wlog.size();
    send_pkt('{8'h77, 8'h88});
    wait_idle();
    chk_log("after_drop_log", b_log, '{8'h02, 8'h77, 8'h88});

    // reset in DRAIN after two of five data words
    b_log = wlog.size(); b_sent = sent_cnt;
    send_pkt('{8'h31, 8'h32, 8'h33, 8'h34, 8'h35});
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk_log("rst_mid_log", b_log, '{8'h05, 8'h31, 8'h32});
    chk("rst_mid_sent", 32'(sent_cnt - b_sent), 32'd0);
    chk("rst_mid_ready", 32'(bus.in_ready), 32'd1);
    b_log = wlog.size();
    send_pkt('{8'h41, 8'h42, 8'h43});
    wait_idle();
    chk_log("rst_next_log", b_log, '{8'h03, 8'h41, 8'h42, 8'h43});

    // sticky overflow flag
    bus.fifo_overflow = 1'b1;
    tick();
    bus.fifo_overflow = 1'b0;
    chk("ovf_set", 32'(bus.proto_err), 32'd1);
    repeat (5) tick();
    chk("ovf_hold", 32'(bus.proto_err), 32'd1);
    rst = 1'b1;
    tick();
    chk("ovf_clear", 32'(bus.proto_err), 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
